// File: rtl/div_arbiter_if.sv
// Divider-side bus of div_arbiter: operands/start/reset out, done/result/status back.
// master = arbiter side, slave = divider side.
interface div_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             div_reset_o;
  logic             div_start_o;
  logic [WIDTH-1:0] div_a_o;
  logic [WIDTH-1:0] div_b_o;
  logic             div_busy_i;
  logic             div_done_i;
  logic             div_valid_i;
  logic             div_dbz_i;
  logic [WIDTH-1:0] div_val_i;
  logic [WIDTH-1:0] div_rem_i;

  modport master (
    output div_reset_o, div_start_o, div_a_o, div_b_o,
    input  div_busy_i, div_done_i, div_valid_i, div_dbz_i, div_val_i, div_rem_i
  );

  modport slave (
    input  div_reset_o, div_start_o, div_a_o, div_b_o,
    output div_busy_i, div_done_i, div_valid_i, div_dbz_i, div_val_i, div_rem_i
  );
endinterface

// File: rtl/div_arbiter.sv
// Round-robin sharing of one iterative divider among NREQ requesters; one division in flight.
// Accept -> start next cycle; done -> one-cycle response next cycle; requests wait while busy.
module div_arbiter #(
  parameter  int WIDTH = 32,
  parameter  int NREQ  = 4,
  localparam int IW    = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset_n_i,
  input  logic [NREQ-1:0]       req_valid_i,
  output logic [NREQ-1:0]       req_ready_o,
  input  logic [NREQ*WIDTH-1:0] req_a_i,
  input  logic [NREQ*WIDTH-1:0] req_b_i,
  output logic [NREQ-1:0]       rsp_valid_o,
  output logic [WIDTH-1:0]      rsp_quo_o,
  output logic [WIDTH-1:0]      rsp_rem_o,
  output logic                  rsp_dbz_o,
  output logic                  busy_o,
  output logic [IW-1:0]         owner_o,
  div_arbiter_if.master         div_if
);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_div_reset;
  logic [IW-1:0]    r_last;
  logic [IW-1:0]    r_owner;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic             r_dbz;

  logic             w_found;
  logic [IW-1:0]    w_sel;
  logic [IW:0]      w_sum;
  logic [IW-1:0]    w_idx;
  logic             w_accept;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [NREQ-1:0]  w_req_ready;
  logic [NREQ-1:0]  w_rsp_valid;
  logic             w_busy;
  logic             w_start;

  // Scan from last+1 with an explicit modulo-NREQ wrap so non power-of-2 NREQ works.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_sum   = '0;
    w_idx   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      w_sum = {1'b0, r_last} + (IW+1)'(i);
      w_idx = IW'((w_sum >= (IW+1)'(NREQ)) ? (w_sum - (IW+1)'(NREQ)) : w_sum);
      if (!w_found && req_valid_i[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_sel == IW'(k)) begin
        w_a = req_a_i[k*WIDTH +: WIDTH];
        w_b = req_b_i[k*WIDTH +: WIDTH];
      end
    end
  end

  assign w_accept = reset_n_i && !r_div_reset && (r_state == IDLE) && w_found;

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) r_state <= IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = START;
      START:   w_next = WAIT;
      WAIT:    if (div_if.div_done_i) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_req_ready = '0;
    w_rsp_valid = '0;
    w_busy      = (r_state != IDLE);
    w_start     = (r_state == START);
    if (w_accept)          w_req_ready = NREQ'(1) << w_sel;
    if (r_state == RESP)   w_rsp_valid = NREQ'(1) << r_owner;
  end

  // div_reset is held one edge past reset release so the divider sees a clean sync reset.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_div_reset <= 1'b1;
      r_last      <= IW'(NREQ-1);
      r_owner     <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_quo       <= '0;
      r_rem       <= '0;
      r_dbz       <= 1'b0;
    end else begin
      r_div_reset <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a     <= w_a;
            r_b     <= w_b;
            r_owner <= w_sel;
          end
        end
        WAIT: begin
          if (div_if.div_done_i) begin
            r_dbz <= div_if.div_dbz_i;
            r_quo <= div_if.div_dbz_i ? '0 : div_if.div_val_i;
            r_rem <= div_if.div_dbz_i ? '0 : div_if.div_rem_i;
          end
        end
        RESP:    r_last <= r_owner;
        default: ;
      endcase
    end
  end

  assign req_ready_o        = w_req_ready;
  assign rsp_valid_o        = w_rsp_valid;
  assign rsp_quo_o          = r_quo;
  assign rsp_rem_o          = r_rem;
  assign rsp_dbz_o          = r_dbz;
  assign busy_o             = w_busy;
  assign owner_o            = r_owner;
  assign div_if.div_reset_o = r_div_reset;
  assign div_if.div_start_o = w_start;
  assign div_if.div_a_o     = r_a;
  assign div_if.div_b_o     = r_b;

  // Divider status is only watched for sanity, never used for sequencing.
  a_start_idle_div: assert property (@(posedge clk) disable iff (!reset_n_i)
    (r_state == START) |-> !div_if.div_busy_i);
  a_done_has_result: assert property (@(posedge clk) disable iff (!reset_n_i)
    ((r_state == WAIT) && div_if.div_done_i) |-> (div_if.div_valid_i || div_if.div_dbz_i));

endmodule

// File: tb/tb_div_arbiter.sv
// Scoreboard bench for div_arbiter with a fixed-latency behavioural divider.
module tb_div_arbiter;
  localparam int W   = 32;
  localparam int N   = 4;
  localparam int LAT = 5;

  typedef struct {
    int          idx;
    logic [W-1:0] quo;
    logic [W-1:0] rem;
    logic         dbz;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_a;
  logic [N*W-1:0]   req_b;
  logic [N-1:0]     rsp_valid;
  logic [W-1:0]     rsp_quo;
  logic [W-1:0]     rsp_rem;
  logic             rsp_dbz;
  logic             busy;
  logic [1:0]       owner;
  logic             inj_done;

  logic             m_busy, m_done, m_dbz;
  logic [W-1:0]     m_a, m_b, m_quo, m_rem;
  int               m_cnt;

  int               n_checks = 0;
  int               n_errors = 0;
  exp_t             sb[$];
  int               glog[$];
  logic             exp_start = 1'b0;
  logic [W-1:0]     exp_a, exp_b;

  div_arbiter_if #(.WIDTH(W)) dif ();

  div_arbiter #(.WIDTH(W), .NREQ(N)) dut (
    .clk         (clk),
    .reset_n_i   (reset_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .rsp_valid_o (rsp_valid),
    .rsp_quo_o   (rsp_quo),
    .rsp_rem_o   (rsp_rem),
    .rsp_dbz_o   (rsp_dbz),
    .busy_o      (busy),
    .owner_o     (owner),
    .div_if      (dif)
  );

  always #5 clk = ~clk;

  assign dif.div_busy_i  = m_busy;
  assign dif.div_done_i  = m_done | inj_done;
  assign dif.div_valid_i = m_done;
  assign dif.div_dbz_i   = m_dbz;
  assign dif.div_val_i   = m_quo;
  assign dif.div_rem_i   = m_rem;

  // Behavioural divider; on divide-by-zero it returns junk that the DUT must mask.
  always @(posedge clk) begin
    m_done <= 1'b0;
    if (dif.div_reset_o) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
      m_dbz  <= 1'b0;
      m_quo  <= '0;
      m_rem  <= '0;
    end else if (dif.div_start_o) begin
      m_busy <= 1'b1;
      m_cnt  <= LAT;
      m_a    <= dif.div_a_o;
      m_b    <= dif.div_b_o;
    end else if (m_busy) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_dbz  <= (m_b == 0);
        m_quo  <= (m_b == 0) ? 32'hDEADBEEF : m_a / m_b;
        m_rem  <= (m_b == 0) ? 32'h12345678 : m_a % m_b;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      exp_start = 1'b0;
    end else begin
      logic [N-1:0] acc;
      check("start_pulse", dif.div_start_o, exp_start);
      if (exp_start) begin
        check("div_a", dif.div_a_o, exp_a);
        check("div_b", dif.div_b_o, exp_b);
      end
      exp_start = 1'b0;
      if (busy) check("ready_while_busy", req_ready, 0);
      acc = req_valid & req_ready;
      if (acc != 0) begin
        int   idx;
        exp_t e;
        idx = 0;
        for (int k = 0; k < N; k++) if (acc[k]) idx = k;
        check("ready_onehot", $countones(req_ready), 1);
        exp_a = req_a[idx*W +: W];
        exp_b = req_b[idx*W +: W];
        e.idx = idx;
        e.dbz = (exp_b == 0);
        e.quo = (exp_b == 0) ? '0 : exp_a / exp_b;
        e.rem = (exp_b == 0) ? '0 : exp_a % exp_b;
        sb.push_back(e);
        glog.push_back(idx);
        exp_start = 1'b1;
      end
      if (rsp_valid != 0) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", rsp_valid, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rsp_valid", rsp_valid, N'(1) << e.idx);
          check("rsp_owner", owner, e.idx);
          check("rsp_quo", rsp_quo, e.quo);
          check("rsp_rem", rsp_rem, e.rem);
          check("rsp_dbz", rsp_dbz, e.dbz);
        end
      end
    end
  end

  task automatic request(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
    bit got;
    got = 0;
    req_a[idx*W +: W] = a;
    req_b[idx*W +: W] = b;
    req_valid[idx]    = 1'b1;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      if (req_ready[idx]) got = 1;
    end
    if (!got) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    req_valid[idx] = 1'b0;
  endtask

  task automatic wait_done();
    bit fin;
    fin = 0;
    for (int c = 0; c < 300 && !fin; c++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0 && !busy) fin = 1;
    end
    if (!fin) check("resp_timeout", 0, 1);
  endtask

  task automatic check_reset_vals();
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_ready", req_ready, 0);
    check("rst_div_reset", dif.div_reset_o, 1);
    check("rst_owner", owner, 0);
    check("rst_quo", rsp_quo, 0);
    check("rst_rem", rsp_rem, 0);
    check("rst_dbz", rsp_dbz, 0);
    check("rst_div_start", dif.div_start_o, 0);
    check("rst_div_a", dif.div_a_o, 0);
    check("rst_div_b", dif.div_b_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_order[5] = '{0, 1, 2, 3, 0};
    reset_n   = 1'b0;
    inj_done  = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_a[0*W +: W] = 32'd50;
    req_b[0*W +: W] = 32'd5;
    req_valid = 4'b0001;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals();

    // Release: divider reset lingers one edge, no grant during that cycle.
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("rel_div_reset_hi", dif.div_reset_o, 1);
    check("rel_ready_lo", req_ready, 0);
    @(posedge clk);
    #1;
    check("rel_div_reset_lo", dif.div_reset_o, 0);
    check("rel_ready_hi", req_ready, 4'b0001);
    request(0, 32'd50, 32'd5);
    wait_done();

    request(2, 32'd100, 32'd7);
    check("single_ready_drop", req_ready, 0);
    wait_done();

    request(1, 32'd5, 32'd0);
    wait_done();
    request(1, 32'd9, 32'd3);
    wait_done();

    // Spurious done in IDLE, then in START.
    @(posedge clk);
    #1;
    inj_done = 1'b1;
    @(negedge clk);
    check("spur_idle_busy", busy, 0);
    @(posedge clk);
    #1;
    inj_done = 1'b0;
    @(negedge clk);
    check("spur_idle_after", busy, 0);
    request(0, 32'd77, 32'd7);
    inj_done = 1'b1;
    @(negedge clk);
    check("spur_start_phase", dif.div_start_o, 1);
    @(posedge clk);
    #1;
    inj_done = 1'b0;
    @(negedge clk);
    check("spur_start_busy", busy, 1);
    check("spur_start_rsp", rsp_valid, 0);
    wait_done();

    // Reset while the divider is mid-operation.
    request(3, 32'd1000, 32'd3);
    repeat (2) @(posedge clk);
    #1;
    check("wait_busy", busy, 1);
    reset_n   = 1'b0;
    sb.delete();
    req_valid = 4'b0100;
    @(negedge clk);
    check_reset_vals();
    @(posedge clk);
    #1;
    reset_n   = 1'b1;
    req_valid = '0;
    repeat (12) @(posedge clk);
    #1;
    check("abort_no_rsp_idle", busy, 0);
    request(3, 32'hFFFFFFFF, 32'h10);
    wait_done();

    // All requesters hold valid: last grant was 3, so order is 0,1,2,3,0.
    glog.delete();
    for (int k = 0; k < N; k++) begin
      req_a[k*W +: W] = 32'(100 + 11*k);
      req_b[k*W +: W] = 32'(k + 2);
    end
    req_valid = '1;
    for (int c = 0; c < 400 && glog.size() < 5; c++) begin
      @(posedge clk);
      #1;
    end
    req_valid = '0;
    check("rr_grant_count", glog.size(), 5);
    for (int i = 0; i < 5 && i < glog.size(); i++) check("rr_order", glog[i], exp_order[i]);
    wait_done();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/div_arbiter.md
Name: div_arbiter

Overview:
Shares one iterative divider (start/busy/done/valid/dbz handshake, W-bit quotient and remainder) among NREQ requesters. Arbitration is round-robin, and the block runs one division at a time. It captures and holds the operands for the whole operation, issues a one-cycle start, and waits for done. It then returns the quotient, remainder and divide-by-zero flag to the requester that owns the operation. It also provides the divider's synchronous reset.

Parameters:
WIDTH, 32, operand/result width in bits (matches divider)
NREQ, 4, number of requesters (>=2)
IW, $clog2(NREQ), requester index width (derived, not overridden)

Ports:
clk  input  1  clock
reset_n_i  input  1  asynchronous active-low reset
req_valid_i  input  NREQ  per-requester request valid
req_ready_o  output  NREQ  one-hot accept; request transfers on valid&ready
req_a_i  input  NREQ*WIDTH  dividends, requester k at [k*WIDTH +: WIDTH]
req_b_i  input  NREQ*WIDTH  divisors, same packing
rsp_valid_o  output  NREQ  one-hot, one-cycle response strobe to owner
rsp_quo_o  output  WIDTH  quotient, qualified by rsp_valid_o
rsp_rem_o  output  WIDTH  remainder, qualified by rsp_valid_o
rsp_dbz_o  output  1  divide-by-zero flag, qualified by rsp_valid_o
busy_o  output  1  high in any state other than IDLE
owner_o  output  IW  index of the current/last granted requester
div_reset_o  output  1  synchronous active-high reset to divider
div_start_o  output  1  divider start pulse
div_a_o  output  WIDTH  divider dividend
div_b_o  output  WIDTH  divider divisor
div_busy_i  input  1  divider busy
div_done_i  input  1  divider done (one-cycle pulse)
div_valid_i  input  1  divider result valid
div_dbz_i  input  1  divider divide-by-zero
div_val_i  input  WIDTH  divider quotient
div_rem_i  input  WIDTH  divider remainder

Behaviour:
- Reset (reset_n_i low, asynchronous): state=IDLE, last=NREQ-1, owner_o=0, busy_o=0, rsp_valid_o=0, rsp_quo_o=0, rsp_rem_o=0, rsp_dbz_o=0, div_start_o=0, div_a_o=0, div_b_o=0, div_reset_o=1. req_ready_o is forced to 0 while reset_n_i is low.
- div_reset_o is a flop. It stays 1 through reset and for the first clk edge after deassertion, then drops to 0. Requests are not accepted (req_ready_o=0) while div_reset_o=1.
- States: IDLE, START, WAIT, RESP.
- IDLE:
  - sel is the first k with req_valid_i[k]=1, scanning last+1, last+2, ... modulo NREQ.
  - req_ready_o[sel]=1 combinationally; all other bits are 0.
  - On the edge: div_a_o/div_b_o <= operands of sel, owner_o <= sel, go to START.
- START: div_start_o=1 for exactly this cycle; go to WAIT.
- WAIT:
  - div_a_o/div_b_o are held stable.
  - On div_done_i=1: latch results, then go to RESP.
    - rsp_dbz_o <= div_dbz_i.
    - If div_dbz_i=1: rsp_quo_o <= 0 and rsp_rem_o <= 0.
    - Otherwise: rsp_quo_o <= div_val_i and rsp_rem_o <= div_rem_i.
- RESP: rsp_valid_o[owner_o]=1 for one cycle; last <= owner_o; go to IDLE.
- rsp_quo_o, rsp_rem_o, rsp_dbz_o hold their values until the next RESP latch.
- Latency:
  - Accept edge T -> div_start_o high in cycle T+1.
  - div_done_i sampled at edge D -> rsp_valid_o high in cycle D+1.
  - Next accept is possible at the edge ending the cycle after RESP, i.e. in IDLE.
- Requester rule: req_valid_i and its operands must stay stable until accepted. The block does not check this.
- A requester that asserts valid again after its response gets lowest priority while others are waiting (round-robin fairness).
- div_done_i, div_valid_i, div_busy_i outside WAIT are ignored (no state change, no response).
- div_busy_i/div_valid_i are not used for sequencing. They are only observed for debug.
- Reset mid-operation (any state): return to the reset values. No response is issued for the aborted request. The divider is reset via div_reset_o. The aborted requester must re-request.
- NREQ not a power of 2: the round-robin wrap is modulo NREQ, never 2^IW.

Test Plan:
- Reset release: div_reset_o=1 until the first edge after deassert, then 0. req_valid_i=4'b0001 during that cycle -> no ready; ready asserts the next cycle.
- Single request: requester 2, a=100, b=7 -> req_ready_o=4'b0100 one cycle, div_start_o one cycle later with div_a_o=100/div_b_o=7, then rsp_valid_o=4'b0100 with quo=14, rem=2, dbz=0.
- All four hold valid continuously -> grants in order 0,1,2,3,0; each rsp_valid_o goes to the matching index; div_start_o never asserts while busy_o=1 from a prior operation.
- Divide by zero: requester 1, a=5, b=0 -> rsp_valid_o=4'b0010, dbz=1, quo=0, rem=0; a following request 9/3 from requester 1 returns quo=3, rem=0, dbz=0.
- Reset in WAIT: assert reset_n_i low mid-divide -> all outputs at reset values, no rsp_valid_o; then a new request 0xFFFFFFFF/0x10 -> quo=0x0FFFFFFF, rem=0xF.
- Spurious div_done_i=1 injected in IDLE and in START -> no rsp_valid_o, state unchanged in IDLE; in START the block proceeds to WAIT and awaits the real done.
